// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// The master drives the strobed byte stream; the loader (slave) drives imem and status.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 6
) ();
    logic [7:0]        byte_in;
    logic              byte_strobe;
    logic              reload;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [2:0]        state_o;

    modport master (
        output byte_in, byte_strobe, reload,
        input  imem_we, imem_addr, imem_wdata, cpu_hold, done, err, state_o
    );

    modport slave (
        input  byte_in, byte_strobe, reload,
        output imem_we, imem_addr, imem_wdata, cpu_hold, done, err, state_o
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: assembles a strobed byte stream into 32-bit little-endian words,
// writes them to instruction memory and releases the core once the checksum matches.
module imem_loader #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);
    // One extra bit so that N == DEPTH fits in the word counter.
    localparam int unsigned CntW  = ADDR_W + 1;
    localparam int unsigned Depth = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        StHdr   = 3'd0,
        StData  = 3'd1,
        StWrite = 3'd2,
        StCsum  = 3'd3,
        StRun   = 3'd4,
        StErr   = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic              s1_q, s2_q, s3_q;
    logic [CntW-1:0]   n_q, n_d;
    logic [CntW-1:0]   word_idx_q, word_idx_d;
    logic [CntW-1:0]   word_inc;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [7:0]        xor_q, xor_d;
    logic [31:0]       asm_q, asm_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              capture;

    assign capture  = s2_q & ~s3_q;
    assign word_inc = word_idx_q + CntW'(1);

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        xor_d      = xor_q;
        asm_d      = asm_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        if (bus.reload) begin
            // Reload wins over a coincident capture.
            state_d    = StHdr;
            n_d        = '0;
            word_idx_d = '0;
            byte_idx_d = '0;
            xor_d      = '0;
            asm_d      = '0;
        end else begin
            case (state_q)
                StHdr: begin
                    if (capture) begin
                        if (bus.byte_in == 8'd0 || 32'(bus.byte_in) > Depth) begin
                            state_d = StErr;
                        end else begin
                            n_d        = CntW'(bus.byte_in);
                            word_idx_d = '0;
                            byte_idx_d = '0;
                            xor_d      = bus.byte_in;
                            state_d    = StData;
                        end
                    end
                end
                StData: begin
                    if (capture) begin
                        asm_d[{byte_idx_q, 3'b000} +: 8] = bus.byte_in;
                        xor_d      = xor_q ^ bus.byte_in;
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            state_d = StWrite;
                            we_d    = 1'b1;
                            addr_d  = word_idx_q[ADDR_W-1:0];
                            wdata_d = asm_d;
                        end
                    end
                end
                StWrite: begin
                    word_idx_d = word_inc;
                    byte_idx_d = '0;
                    state_d    = (word_inc == n_q) ? StCsum : StData;
                end
                StCsum: begin
                    if (capture) begin
                        state_d = (bus.byte_in == xor_q) ? StRun : StErr;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StHdr;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            n_q        <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            xor_q      <= '0;
            asm_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            s1_q       <= bus.byte_strobe;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            n_q        <= n_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            xor_q      <= xor_d;
            asm_q      <= asm_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.cpu_hold   = (state_q != StRun);
    assign bus.done       = (state_q == StRun);
    assign bus.err        = (state_q == StErr);
    assign bus.state_o    = state_q;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are sent and
// popped by an independent monitor; final states come from a stream-level model.
module tb_imem_loader;
    localparam int unsigned AW    = 6;
    localparam int unsigned Depth = 64;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(AW)) bus ();
    imem_loader #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int         checks = 0;
    int         errors = 0;
    wr_t        exp_q[$];
    logic [7:0] sent[$];
    logic [7:0] tx[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    wr_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (bus.imem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %h expected none",
                             bus.imem_addr, bus.imem_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("write_addr", 32'(bus.imem_addr), 32'(mon_e.addr));
                    chk("write_data", bus.imem_wdata, mon_e.data);
                    chk("hold_during_write", 32'(bus.cpu_hold), 32'd1);
                end
            end
        end
    end

    // Stream-level model: final state implied by the bytes delivered since reload/reset.
    function automatic int exp_state();
        int n, k;
        logic [7:0] x;
        if (sent.size() == 0) return 0;
        n = int'(sent[0]);
        if (n == 0 || n > Depth) return 5;
        k = sent.size() - 1;
        if (k < 4 * n) return 1;
        if (k == 4 * n) return 3;
        x = 8'h00;
        for (int i = 0; i <= 4 * n; i++) x ^= sent[i];
        return (sent[4 * n + 1] == x) ? 4 : 5;
    endfunction

    // Record the byte; if it completes an in-range word, queue the expected write.
    task automatic note_byte(input logic [7:0] b);
        int n, idx;
        wr_t w;
        sent.push_back(b);
        n   = int'(sent[0]);
        idx = sent.size() - 1;
        if (n >= 1 && n <= Depth && idx >= 1 && idx <= 4 * n && idx % 4 == 0) begin
            w.addr = AW'(idx / 4 - 1);
            w.data = {sent[idx], sent[idx-1], sent[idx-2], sent[idx-3]};
            exp_q.push_back(w);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
        @(posedge clk);
        #1;
        note_byte(b);
        bus.byte_in     = b;
        bus.byte_strobe = 1'b1;
        repeat (hi) @(posedge clk);
        #1 bus.byte_strobe = 1'b0;
        repeat (lo - 1) @(posedge clk);
    endtask

    task automatic send_tx();
        foreach (tx[i]) send_byte(tx[i], int'($urandom_range(2, 4)), int'($urandom_range(2, 4)));
    endtask

    task automatic do_reload();
        @(posedge clk);
        #1 bus.reload = 1'b1;
        @(posedge clk);
        #1 bus.reload = 1'b0;
        sent.delete();
    endtask

    // Strobe whose capture edge coincides with a reload pulse.
    task automatic send_drop(input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.byte_in     = b;
        bus.byte_strobe = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 bus.reload = 1'b1;
        @(posedge clk);
        #1;
        bus.reload      = 1'b0;
        bus.byte_strobe = 1'b0;
        sent.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic build(input int n, input int nbytes, input bit good);
        logic [7:0] x, b;
        tx.delete();
        tx.push_back(8'(n));
        x = 8'(n);
        for (int i = 0; i < nbytes; i++) begin
            b = 8'($urandom);
            tx.push_back(b);
            x ^= b;
        end
        tx.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
    endtask

    task automatic check_state(input string name);
        int st;
        repeat (8) @(posedge clk);
        @(negedge clk);
        st = exp_state();
        chk({name, ".state"}, 32'(bus.state_o), 32'(st));
        chk({name, ".done"}, 32'(bus.done), 32'(st == 4));
        chk({name, ".err"}, 32'(bus.err), 32'(st == 5));
        chk({name, ".hold"}, 32'(bus.cpu_hold), 32'(st != 4));
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, ".we"}, 32'(bus.imem_we), 32'd0);
        chk({name, ".addr"}, 32'(bus.imem_addr), 32'd0);
        chk({name, ".wdata"}, bus.imem_wdata, 32'd0);
        chk({name, ".hold"}, 32'(bus.cpu_hold), 32'd1);
        chk({name, ".done"}, 32'(bus.done), 32'd0);
        chk({name, ".err"}, 32'(bus.err), 32'd0);
        chk({name, ".state"}, 32'(bus.state_o), 32'd0);
    endtask

    initial begin
        int n;
        rst             = 1'b1;
        bus.byte_in     = 8'h00;
        bus.byte_strobe = 1'b0;
        bus.reload      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Good load, then strobes in RUN must be ignored.
        tx = '{8'h02, 8'h20, 8'h00, 8'h02, 8'h8B, 8'h01, 8'h00, 8'h00, 8'hF8, 8'h52};
        send_tx();
        check_state("good_load");
        tx = '{8'h01, 8'hAA, 8'h55};
        send_tx();
        check_state("run_ignore");

        // Bad checksum, then strobes in ERR.
        do_reload();
        tx = '{8'h02, 8'h20, 8'h00, 8'h02, 8'h8B, 8'h01, 8'h00, 8'h00, 8'hF8, 8'h53};
        send_tx();
        check_state("bad_csum");
        tx = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_tx();
        check_state("err_ignore");

        // Header bounds.
        do_reload();
        tx = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_tx();
        check_state("hdr_zero");
        do_reload();
        tx = '{8'h41, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_tx();
        check_state("hdr_over");
        do_reload();
        build(64, 256, 1'b1);
        send_tx();
        check_state("hdr_full");

        // Reload mid-word, then a clean single-word load.
        do_reload();
        tx = '{8'h01, 8'h11, 8'h22};
        send_tx();
        do_reload();
        check_state("reload_mid");
        tx = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
        send_tx();
        check_state("after_reload");

        // Capture coincident with reload is dropped; a long strobe gives one capture.
        do_reload();
        send_drop(8'h01);
        check_state("drop_on_reload");
        send_byte(8'h01, 10, 3);
        send_byte(8'hC3, 10, 3);
        tx = '{8'hA5, 8'h5A, 8'h3C};
        send_tx();
        send_byte(8'h01 ^ 8'hC3 ^ 8'hA5 ^ 8'h5A ^ 8'h3C, 2, 3);
        check_state("long_strobe");

        // Reset after three data bytes: no write, reset values, then a full load.
        do_reload();
        tx = '{8'h02, 8'hDE, 8'hAD, 8'hBE};
        send_tx();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst_mid");
        @(posedge clk);
        #1 rst = 1'b0;
        sent.delete();
        build(3, 12, 1'b1);
        send_tx();
        check_state("after_rst");

        // Randomized streams: bad headers, bad checksums, truncated streams.
        for (int it = 0; it < 20; it++) begin
            do_reload();
            if ($urandom_range(0, 9) == 0) begin
                n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(65, 255));
                build(n, 3, 1'b1);
            end else begin
                n = int'($urandom_range(1, 8));
                build(n, 4 * n, $urandom_range(0, 9) < 7);
                if ($urandom_range(0, 3) == 0) begin
                    int cut;
                    cut = int'($urandom_range(1, tx.size() - 1));
                    while (tx.size() > cut) void'(tx.pop_back());
                end
            end
            send_tx();
            check_state("random");
        end

        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
